regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-read-port general-purpose register file with a per-register pending-write scoreboard, for the pipelined MIPS core. It replaces the fixed 32x32, two-port array with configurable width, depth and read-port count. It adds a hardwired zero register and same-cycle write-to-read bypass. It also tracks which registers have an issued but not yet written-back producer, so decode can stall on RAW hazards without a separate hazard unit.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W
- NREAD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes and claims

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all registers and busy bits
- rnum  in  NREAD*ADDR_W  read indices; port k = bits [k*ADDR_W +: ADDR_W]
- rdata  out  NREAD*DATA_W  read data, port k = bits [k*DATA_W +: DATA_W]
- rbusy  out  NREAD  1 = port k's register has an outstanding producer
- write  in  1  writeback strobe
- wnum  in  ADDR_W  writeback index
- wdata  in  DATA_W  writeback data
- claim  in  1  issue strobe; marks cnum pending
- cnum  in  ADDR_W  destination index of the issuing instruction
- any_busy  out  1  OR of all busy bits (drain indicator)

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus 2**ADDR_W busy bits.
- Reads are combinational from current state plus bypass.
- Bypass rule: if write=1 and wnum==rnum[k], then rdata[k]=wdata and rbusy[k]=0.
- Otherwise rdata[k]=reg[rnum[k]] and rbusy[k]=busy[rnum[k]].
- ZERO_REG=1:
  - rnum[k]==0 gives rdata[k]=0 and rbusy[k]=0, with no bypass.
  - Writes and claims to index 0 are dropped.
- Busy update at the clock edge, in this order:
  - the write clears busy[wnum];
  - the claim then sets busy[cnum].
- Simultaneous claim and write to the same index: busy ends at 1, and the data is still written. This covers a back-to-back WAW where the new producer wins.
- Claim of an already-busy register: busy stays 1 (no counting). In-order issue guarantees the latest producer writes back last.
- Write without a prior claim: legal. Data is written and busy stays 0.
- any_busy reflects the registered busy bits only, with no bypass.

## Timing
- Read latency: 0 cycles (combinational). Write/claim take effect on the rising clock edge.
- Reset is asynchronous: registers=0 and busy=0 immediately on assertion. During reset, rdata is 0 and rbusy=0 on every port (the bypass is suppressed); any_busy=0.
- Reset mid-operation discards all pending claims. A write in the cycle reset deasserts is taken normally.
- All outputs depend only on state and the current rnum/write/wnum/wdata. There is no combinational path from claim to any output.

## Structure
- Shared package regfile_pkg:
  - default DATA_W and ADDR_W constants;
  - REG_ZERO index constant;
  - a helper function for the port slice offset.
- One sub-module, reg_busy_table: busy-bit array with clear-then-set update, its read muxes and the any_busy reduction.
- Data array and bypass muxes live in the top.
- Read muxes use indexed selects, not tri-state buses.

## Test plan
- Reset then read: assert reset, read r5 and r31 on both ports -> rdata=0, rbusy=0, any_busy=0.
- Write then read: write r7=0xDEADBEEF, next cycle read r7 on port 1 -> 0xDEADBEEF, rbusy=0.
- Bypass: in the same cycle, write r3=0x12345678 and rnum0=3 -> rdata0=0x12345678 combinationally.
- Zero register:
  - write r0=0xFFFFFFFF and claim r0 -> reading r0 gives 0, rbusy=0, any_busy=0;
  - with ZERO_REG=0 the same write reads back 0xFFFFFFFF.
- Scoreboard:
  - claim r9 -> next cycle rbusy=1 for r9, any_busy=1;
  - write r9=0x55 -> rbusy=0 and rdata=0x55 in that cycle;
  - next cycle any_busy=0.
- Collision and reset:
  - claim r4 and write r4=0xA in the same cycle -> next cycle rbusy=1 and rdata=0xA;
  - then assert reset mid-cycle -> busy=0 and rdata=0 immediately;
  - run with NREAD=3 and DATA_W=16.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file and its scoreboard.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int REG_ZERO   = 0;

  // LSB position of port k in a bus of packed, equally sized per-port fields.
  function automatic int port_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Read/write/claim bundle between the decode/writeback stages and the register file.
// Latency: n/a (wires only).
// Backpressure: none; the rbusy/any_busy outputs are the stall indication for decode.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2
) ();

  logic [NREAD*ADDR_W-1:0] rnum;
  logic [NREAD*DATA_W-1:0] rdata;
  logic [NREAD-1:0]        rbusy;
  logic                    write;
  logic [ADDR_W-1:0]       wnum;
  logic [DATA_W-1:0]       wdata;
  logic                    claim;
  logic [ADDR_W-1:0]       cnum;
  logic                    any_busy;

  modport master (
    output rnum, write, wnum, wdata, claim, cnum,
    input  rdata, rbusy, any_busy
  );

  modport slave (
    input  rnum, write, wnum, wdata, claim, cnum,
    output rdata, rbusy, any_busy
  );

endinterface

// File: rtl/reg_busy_table.sv
// Pending-producer bit per register: clear on writeback, then set on claim.
// Latency: reads are combinational from registered bits; updates land on the clock edge.
// Backpressure: none; callers stall on rbusy_o / any_busy_o themselves.
module reg_busy_table
  import regfile_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NREAD  = 2
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    clr_i,
  input  logic [ADDR_W-1:0]       clr_num_i,
  input  logic                    set_i,
  input  logic [ADDR_W-1:0]       set_num_i,
  input  logic [NREAD*ADDR_W-1:0] rnum_i,
  output logic [NREAD-1:0]        rbusy_o,
  output logic                    any_busy_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Clear first so a claim in the same cycle as the writeback wins (WAW: new producer owns the reg).
  always_comb begin
    busy_d = busy_q;
    if (clr_i) busy_d[clr_num_i] = 1'b0;
    if (set_i) busy_d[set_num_i] = 1'b1;
  end

  // Busy bits; reset discards every outstanding claim.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    localparam int AL = port_lsb(k, ADDR_W);
    assign rbusy_o[k] = busy_q[rnum_i[AL +: ADDR_W]];
  end

  assign any_busy_o = |busy_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with optional zero register, write-to-read bypass and RAW scoreboard.
// Latency: reads 0 cycles (combinational, with same-cycle writeback bypass); writes/claims on the clock edge.
// Backpressure: none; decode stalls on rbusy, drain logic watches any_busy.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                 clock,
  input  logic                 reset,
  regfile_scoreboard_if.slave  bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wr_en;
  logic              cl_en;
  logic [NREAD-1:0]  busy_raw;

  // Index 0 is a constant when ZERO_REG is set, so neither data nor busy may be touched there.
  assign wr_en = bus.write && !(ZERO_REG && (bus.wnum == ADDR_W'(REG_ZERO)));
  assign cl_en = bus.claim && !(ZERO_REG && (bus.cnum == ADDR_W'(REG_ZERO)));

  // Data array; reset clears every register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[bus.wnum] <= bus.wdata;
    end
  end

  reg_busy_table #(
    .ADDR_W (ADDR_W),
    .NREAD  (NREAD)
  ) u_busy (
    .clock_i    (clock),
    .reset_i    (reset),
    .clr_i      (wr_en),
    .clr_num_i  (bus.wnum),
    .set_i      (cl_en),
    .set_num_i  (bus.cnum),
    .rnum_i     (bus.rnum),
    .rbusy_o    (busy_raw),
    .any_busy_o (bus.any_busy)
  );

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    localparam int AL = port_lsb(k, ADDR_W);
    localparam int DL = port_lsb(k, DATA_W);

    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] rd;
    logic              rb;

    assign idx = bus.rnum[AL +: ADDR_W];

    // Per-port read: zero reg and reset force 0, otherwise a matching writeback bypasses the array.
    always_comb begin
      rd = mem_q[idx];
      rb = busy_raw[k];
      if (reset || (ZERO_REG && (idx == ADDR_W'(REG_ZERO)))) begin
        rd = '0;
        rb = 1'b0;
      end else if (bus.write && (bus.wnum == idx)) begin
        rd = bus.wdata;
        rb = 1'b0;
      end
    end

    assign bus.rdata[DL +: DATA_W] = rd;
    assign bus.rbusy[k]            = rb;
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench: two instances (32b/2 ports/zero reg, 16b/3 ports/no zero reg) driven identically.
// Driver pushes reference-model expectations into a queue; monitor pops and compares each cycle.
// Reference model is a plain array of values and busy flags per instance.
module tb_regfile_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) ifa ();
  regfile_scoreboard_if #(.DATA_W(16), .ADDR_W(5), .NREAD(3)) ifb ();

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1'b1)) u_a (
    .clock (clk),
    .reset (rst),
    .bus   (ifa)
  );

  regfile_scoreboard #(.DATA_W(16), .ADDR_W(5), .NREAD(3), .ZERO_REG(1'b0)) u_b (
    .clock (clk),
    .reset (rst),
    .bus   (ifb)
  );

  typedef struct packed {
    logic [1:0][31:0] rda;
    logic [1:0]       rba;
    logic             aba;
    logic [2:0][15:0] rdb;
    logic [2:0]       rbb;
    logic             abb;
  } exp_t;

  exp_t q[$];
  event sample_ev;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] ma [32];
  bit          ba [32];
  logic [15:0] mb [32];
  bit          bb [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      ma[i] = '0; ba[i] = 1'b0; mb[i] = '0; bb[i] = 1'b0;
    end
  endtask

  // One cycle: drive at negedge, queue expectations, then advance the model at the rising edge.
  task automatic cyc(input bit r, input logic [4:0] n0, input logic [4:0] n1, input logic [4:0] n2,
                     input bit w, input logic [4:0] wn, input logic [31:0] wd,
                     input bit c, input logic [4:0] cn);
    exp_t e;
    logic [4:0] nk [3];
    @(negedge clk);
    rst = r;
    if (r) model_clear();
    ifa.rnum = {n1, n0};        ifb.rnum  = {n2, n1, n0};
    ifa.write = w;              ifb.write = w;
    ifa.wnum = wn;              ifb.wnum  = wn;
    ifa.wdata = wd;             ifb.wdata = wd[15:0];
    ifa.claim = c;              ifb.claim = c;
    ifa.cnum = cn;              ifb.cnum  = cn;
    #1;
    nk[0] = n0; nk[1] = n1; nk[2] = n2;
    e = '0;
    for (int k = 0; k < 3; k++) begin
      if (k < 2) begin
        if (r || nk[k] == 5'd0)      begin e.rda[k] = '0; e.rba[k] = 1'b0; end
        else if (w && wn == nk[k])   begin e.rda[k] = wd; e.rba[k] = 1'b0; end
        else                         begin e.rda[k] = ma[nk[k]]; e.rba[k] = ba[nk[k]]; end
      end
      if (r)                         begin e.rdb[k] = '0; e.rbb[k] = 1'b0; end
      else if (w && wn == nk[k])     begin e.rdb[k] = wd[15:0]; e.rbb[k] = 1'b0; end
      else                           begin e.rdb[k] = mb[nk[k]]; e.rbb[k] = bb[nk[k]]; end
    end
    for (int i = 0; i < 32; i++) begin
      if (ba[i]) e.aba = 1'b1;
      if (bb[i]) e.abb = 1'b1;
    end
    q.push_back(e);
    -> sample_ev;
    @(posedge clk);
    if (!r) begin
      if (w && wn != 5'd0) begin ma[wn] = wd; ba[wn] = 1'b0; end
      if (c && cn != 5'd0) ba[cn] = 1'b1;
      if (w) begin mb[wn] = wd[15:0]; bb[wn] = 1'b0; end
      if (c) bb[cn] = 1'b1;
    end
  endtask

  function automatic logic [4:0] pick();
    if ($urandom_range(0, 1) == 1) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  // Monitor: after each drive, let outputs settle and compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      if (q.size() == 0) begin
        chk("queue_underflow", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        for (int k = 0; k < 2; k++) begin
          chk($sformatf("a_rdata%0d", k), ifa.rdata[k*32 +: 32], e.rda[k]);
          chk($sformatf("a_rbusy%0d", k), 32'(ifa.rbusy[k]), 32'(e.rba[k]));
        end
        chk("a_any_busy", 32'(ifa.any_busy), 32'(e.aba));
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("b_rdata%0d", k), 32'(ifb.rdata[k*16 +: 16]), 32'(e.rdb[k]));
          chk($sformatf("b_rbusy%0d", k), 32'(ifb.rbusy[k]), 32'(e.rbb[k]));
        end
        chk("b_any_busy", 32'(ifb.any_busy), 32'(e.abb));
      end
    end
  end

  initial begin
    ifa.rnum = '0; ifa.write = 1'b0; ifa.wnum = '0; ifa.wdata = '0; ifa.claim = 1'b0; ifa.cnum = '0;
    ifb.rnum = '0; ifb.write = 1'b0; ifb.wnum = '0; ifb.wdata = '0; ifb.claim = 1'b0; ifb.cnum = '0;
    model_clear();

    // Reset: outputs 0 even with a write to a read index pending (bypass suppressed).
    cyc(1, 5'd5, 5'd31, 5'd5, 1, 5'd5, 32'hAAAA_5555, 1, 5'd5);
    // Write taken in the cycle reset deasserts, then read back and same-cycle bypass.
    cyc(0, 5'd0, 5'd0, 5'd0, 1, 5'd7, 32'hDEAD_BEEF, 0, 5'd0);
    cyc(0, 5'd3, 5'd7, 5'd7, 1, 5'd3, 32'h1234_5678, 0, 5'd0);
    // Zero register: write and claim to r0.
    cyc(0, 5'd0, 5'd0, 5'd0, 1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0);
    cyc(0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'h0, 1, 5'd9);
    // Scoreboard: claim r9, busy visible, writeback clears in the same cycle.
    cyc(0, 5'd9, 5'd9, 5'd9, 0, 5'd0, 32'h0, 0, 5'd0);
    cyc(0, 5'd9, 5'd9, 5'd9, 1, 5'd9, 32'h55, 0, 5'd0);
    cyc(0, 5'd9, 5'd0, 5'd9, 0, 5'd0, 32'h0, 0, 5'd0);
    // Claim and write r4 together: busy ends set, data written.
    cyc(0, 5'd4, 5'd4, 5'd4, 1, 5'd4, 32'hA, 1, 5'd4);
    cyc(0, 5'd4, 5'd4, 5'd4, 0, 5'd0, 32'h0, 0, 5'd0);
    // Mid-operation reset, then a write in the deassert cycle.
    cyc(1, 5'd4, 5'd4, 5'd4, 1, 5'd4, 32'h77, 0, 5'd0);
    cyc(0, 5'd4, 5'd4, 5'd4, 1, 5'd4, 32'h66, 0, 5'd0);
    cyc(0, 5'd4, 5'd4, 5'd4, 0, 5'd0, 32'h0, 1, 5'd4);
    cyc(0, 5'd4, 5'd4, 5'd4, 0, 5'd0, 32'h0, 1, 5'd4);

    // Random traffic with occasional resets.
    for (int i = 0; i < 500; i++) begin
      cyc(($urandom_range(0, 63) == 0), pick(), pick(), pick(),
          ($urandom_range(0, 1) == 1), pick(), $urandom,
          ($urandom_range(0, 2) == 0), pick());
    end

    @(negedge clk);
    #3;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
